// File: rtl/seq_mult_pkg.sv
// Shared types and sizing helpers for the segment-loaded sequential multiplier.
// Optional signed support is enabled with SEQ_MULT_SIGNED_EN (see seq_mult_seg).
package seq_mult_pkg;

   typedef enum logic [1:0] {
      ST_LOAD = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   function automatic int nseg(input int width, input int seg_w);
      return width / seg_w;
   endfunction

   function automatic int seg_cnt_w(input int width, input int seg_w);
      return $clog2(2 * (width / seg_w));
   endfunction

   function automatic int bit_cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/seq_mult_seg_if.sv
// Operand-segment input and product handshake bundle for seq_mult_seg.
// op_signed exists only when SEQ_MULT_SIGNED_EN is defined.
interface seq_mult_seg_if #(
   parameter int WIDTH = 8,
   parameter int SEG_W = 4
);
   logic [SEG_W-1:0]   seg_in;
   logic               seg_valid;
   logic               seg_ack;
   logic [2*WIDTH-1:0] prod;
   logic               prod_valid;
   logic               prod_ready;
   logic               busy;
`ifdef SEQ_MULT_SIGNED_EN
   logic               op_signed;

   modport master (output seg_in, seg_valid, prod_ready, op_signed,
                   input  seg_ack, prod, prod_valid, busy);
   modport slave  (input  seg_in, seg_valid, prod_ready, op_signed,
                   output seg_ack, prod, prod_valid, busy);
`else
   modport master (output seg_in, seg_valid, prod_ready,
                   input  seg_ack, prod, prod_valid, busy);
   modport slave  (input  seg_in, seg_valid, prod_ready,
                   output seg_ack, prod, prod_valid, busy);
`endif
endinterface

// File: rtl/seq_mult_seg_deser.sv
// Segment deserialiser: slot counter plus A/B operand registers, A first, LS segment first.
// load_done flags the transfer that fills the last B segment.
module seg_deser
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SEG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             xfer,
   input  logic [SEG_W-1:0] seg,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic             load_done
);
   localparam int NSEG = nseg(WIDTH, SEG_W);
   localparam int SCW  = seg_cnt_w(WIDTH, SEG_W);
   localparam logic [SCW-1:0] LAST_SLOT = SCW'(2 * NSEG - 1);

   logic [SCW-1:0] seg_cnt;

   assign load_done = xfer && (seg_cnt == LAST_SLOT);

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_cnt <= '0;
      end else if (xfer) begin
         seg_cnt <= load_done ? '0 : seg_cnt + SCW'(1);
      end
   end

   // Operand slots hold data only; a reset just restarts the slot count.
   always_ff @(posedge clk) begin
      if (xfer) begin
         for (int i = 0; i < NSEG; i++) begin
            if (seg_cnt == SCW'(i))        a[i*SEG_W +: SEG_W] <= seg;
            if (seg_cnt == SCW'(i + NSEG)) b[i*SEG_W +: SEG_W] <= seg;
         end
      end
   end

endmodule

// File: rtl/seq_mult_seg.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, valid/ready result port.
// Define SEQ_MULT_SIGNED_EN to add op_signed (two's-complement operands).
module seq_mult_seg
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SEG_W = 4
) (
   input  logic          clk,
   input  logic          rst,
   seq_mult_seg_if.slave bus
);
   localparam int AW  = 2 * WIDTH + 1;
   localparam int BCW = bit_cnt_w(WIDTH);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

   state_t           state;
   logic [BCW-1:0]   bit_cnt;
   logic [AW-1:0]    acc;
   logic [AW-1:0]    a_ext;
   logic [AW-1:0]    a_shift;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             b_bit;
   logic             seg_ack;
   logic             load_done;
   logic             neg_step;
   logic             prod_valid_q;
   logic             busy_q;
   logic             carry_unused;

   assign seg_ack = !rst && (state == ST_LOAD) && bus.seg_valid;

   seg_deser #(.WIDTH(WIDTH), .SEG_W(SEG_W)) u_deser (
      .clk       (clk),
      .rst       (rst),
      .xfer      (seg_ack),
      .seg       (bus.seg_in),
      .a         (a),
      .b         (b),
      .load_done (load_done)
   );

`ifdef SEQ_MULT_SIGNED_EN
   logic signed_q;

   always_ff @(posedge clk) begin
      if (rst)            signed_q <= 1'b0;
      else if (load_done) signed_q <= bus.op_signed;
   end

   // Signed: the B MSB carries weight -2^(WIDTH-1), so that step subtracts.
   assign a_ext    = {{(WIDTH + 1){signed_q & a[WIDTH-1]}}, a};
   assign neg_step = signed_q && (bit_cnt == LAST_BIT);
`else
   assign a_ext    = {{(WIDTH + 1){1'b0}}, a};
   assign neg_step = 1'b0;
`endif

   assign a_shift = a_ext << bit_cnt;
   assign b_bit   = |(b & (WIDTH'(1) << bit_cnt));

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_LOAD;
         bit_cnt      <= '0;
         acc          <= '0;
         prod_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         case (state)
            ST_LOAD: begin
               if (load_done) begin
                  state   <= ST_RUN;
                  bit_cnt <= '0;
                  acc     <= '0;
                  busy_q  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (b_bit) acc <= neg_step ? acc - a_shift : acc + a_shift;
               bit_cnt <= bit_cnt + BCW'(1);
               if (bit_cnt == LAST_BIT) begin
                  state        <= ST_DONE;
                  prod_valid_q <= 1'b1;
               end
            end
            ST_DONE: begin
               if (bus.prod_ready) begin
                  state        <= ST_LOAD;
                  prod_valid_q <= 1'b0;
                  busy_q       <= 1'b0;
               end
            end
            default: begin
               state        <= ST_LOAD;
               prod_valid_q <= 1'b0;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

   // The extra accumulator bit only absorbs the carry; the product is the low 2*WIDTH bits.
   assign carry_unused   = acc[AW-1];
   assign bus.prod       = acc[2*WIDTH-1:0];
   assign bus.prod_valid = prod_valid_q;
   assign bus.busy       = busy_q;
   assign bus.seg_ack    = seg_ack;

endmodule

// File: tb/tb_seq_mult_seg.sv
// Directed self-checking bench for seq_mult_seg, WIDTH=8, SEG_W=4.
// Signed-mode scenario runs when SEQ_MULT_SIGNED_EN is defined.
module tb_seq_mult_seg;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   seq_mult_seg_if #(.WIDTH(8), .SEG_W(4)) bus ();

   seq_mult_seg #(.WIDTH(8), .SEG_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic [3:0] v);
      int n;
      bus.seg_in    = v;
      bus.seg_valid = 1'b1;
      n = 0;
      #1;
      while (!bus.seg_ack && n < 50) begin
         @(posedge clk); #2;
         n++;
      end
      if (n == 50) begin
         fails++;
         $display("FAIL send_timeout seg_ack=0 required 1");
      end
      @(posedge clk); #1;
      bus.seg_valid = 1'b0;
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         output int lat, output logic [15:0] p, output logic busy_ok);
      send(a[3:0]); send(a[7:4]); send(b[3:0]); send(b[7:4]);
      lat     = 0;
      busy_ok = bus.busy;
      while (!bus.prod_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         busy_ok &= bus.busy;
      end
      p = bus.prod;
   endtask

   task automatic ack();
      bus.prod_ready = 1'b1;
      @(posedge clk); #1;
      bus.prod_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.seg_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests++; if (bus.prod !== 16'h0000) begin fails++; $display("FAIL reset_prod got %h want 0000", bus.prod); end
      tests++; if (bus.prod_valid !== 1'b0) begin fails++; $display("FAIL reset_prod_valid got %b want 0", bus.prod_valid); end
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      tests++; if (bus.seg_ack !== 1'b0) begin fails++; $display("FAIL reset_seg_ack got %b want 0", bus.seg_ack); end
      rst = 1'b0;
      bus.seg_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int lat; logic [15:0] p; logic bok;
      run_op(8'hB7, 8'h5C, lat, p, bok);
      tests++; if (p !== 16'h41C4) begin fails++; $display("FAIL basic_prod got %h want 41c4", p); end
      tests++; if (lat !== 8) begin fails++; $display("FAIL basic_latency got %0d want 8", lat); end
      tests++; if (bok !== 1'b1) begin fails++; $display("FAIL basic_busy got %b want 1", bok); end
      ack();
      tests++; if (bus.prod_valid !== 1'b0) begin fails++; $display("FAIL basic_ack_valid got %b want 0", bus.prod_valid); end
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL basic_ack_busy got %b want 0", bus.busy); end
   endtask

   task automatic test_max();
      int lat; logic [15:0] p; logic bok;
      run_op(8'hFF, 8'hFF, lat, p, bok);
      tests++; if (p !== 16'hFE01) begin fails++; $display("FAIL max_prod got %h want fe01", p); end
      tests++; if (lat !== 8) begin fails++; $display("FAIL max_latency got %0d want 8", lat); end
      ack();
   endtask

   task automatic test_zero();
      int lat; logic [15:0] p; logic bok;
      run_op(8'h00, 8'hA5, lat, p, bok);
      tests++; if (p !== 16'h0000) begin fails++; $display("FAIL zero_prod got %h want 0000", p); end
      tests++; if (lat !== 8) begin fails++; $display("FAIL zero_latency got %0d want 8", lat); end
      tests++; if (bok !== 1'b1) begin fails++; $display("FAIL zero_busy got %b want 1", bok); end
      ack();
   endtask

   task automatic test_hold();
      int lat; logic [15:0] p; logic bok;
      run_op(8'h12, 8'h34, lat, p, bok);
      tests++; if (p !== 16'h03A8) begin fails++; $display("FAIL hold_prod got %h want 03a8", p); end
      bus.seg_in    = 4'h1;
      bus.seg_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         tests++; if (bus.prod_valid !== 1'b1) begin fails++; $display("FAIL hold_valid cyc %0d got %b want 1", i, bus.prod_valid); end
         tests++; if (bus.prod !== 16'h03A8) begin fails++; $display("FAIL hold_prod_stable cyc %0d got %h want 03a8", i, bus.prod); end
         tests++; if (bus.seg_ack !== 1'b0) begin fails++; $display("FAIL hold_seg_ack cyc %0d got %b want 0", i, bus.seg_ack); end
         @(posedge clk); #1;
      end
      bus.prod_ready = 1'b1;
      @(posedge clk); #1;
      bus.prod_ready = 1'b0;
      #1;
      tests++; if (bus.seg_ack !== 1'b1) begin fails++; $display("FAIL hold_post_ack got %b want 1", bus.seg_ack); end
      tests++; if (bus.prod_valid !== 1'b0) begin fails++; $display("FAIL hold_post_valid got %b want 0", bus.prod_valid); end
      bus.seg_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int lat; logic [15:0] p; logic bok;
      send(4'hF); send(4'hF); send(4'hF);
      rst = 1'b1;
      bus.seg_valid = 1'b1;
      @(posedge clk); #1;
      tests++; if (bus.prod !== 16'h0000) begin fails++; $display("FAIL rstmid_prod got %h want 0000", bus.prod); end
      tests++; if (bus.prod_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid got %b want 0", bus.prod_valid); end
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
      tests++; if (bus.seg_ack !== 1'b0) begin fails++; $display("FAIL rstmid_seg_ack got %b want 0", bus.seg_ack); end
      @(posedge clk); #1;
      rst = 1'b0;
      bus.seg_valid = 1'b0;
      run_op(8'h03, 8'h02, lat, p, bok);
      tests++; if (p !== 16'h0006) begin fails++; $display("FAIL rstmid_after_prod got %h want 0006", p); end
      tests++; if (lat !== 8) begin fails++; $display("FAIL rstmid_after_latency got %0d want 8", lat); end
      ack();
   endtask

   task automatic test_back_to_back();
      int lat; logic [15:0] p; logic bok;
      bus.prod_ready = 1'b1;
      run_op(8'h0F, 8'h0F, lat, p, bok);
      tests++; if (p !== 16'h00E1) begin fails++; $display("FAIL b2b_prod got %h want 00e1", p); end
      tests++; if (lat !== 8) begin fails++; $display("FAIL b2b_latency got %0d want 8", lat); end
      bus.seg_in    = 4'h0;
      bus.seg_valid = 1'b1;
      @(posedge clk); #1;
      bus.prod_ready = 1'b0;
      #1;
      tests++; if (bus.prod_valid !== 1'b0) begin fails++; $display("FAIL b2b_one_cycle_done got %b want 0", bus.prod_valid); end
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL b2b_busy got %b want 0", bus.busy); end
      tests++; if (bus.seg_ack !== 1'b1) begin fails++; $display("FAIL b2b_seg_ack got %b want 1", bus.seg_ack); end
      bus.seg_valid = 1'b0;
      @(posedge clk); #1;
   endtask

`ifdef SEQ_MULT_SIGNED_EN
   task automatic test_signed();
      int lat; logic [15:0] p; logic bok;
      bus.op_signed = 1'b1;
      run_op(8'hFE, 8'h03, lat, p, bok);
      tests++; if (p !== 16'hFFFA) begin fails++; $display("FAIL signed_prod got %h want fffa", p); end
      tests++; if (lat !== 8) begin fails++; $display("FAIL signed_latency got %0d want 8", lat); end
      ack();
      bus.op_signed = 1'b0;
      run_op(8'hFE, 8'h03, lat, p, bok);
      tests++; if (p !== 16'h02FA) begin fails++; $display("FAIL unsigned_mode_prod got %h want 02fa", p); end
      ack();
   endtask
`endif

   initial begin
      bus.seg_in     = '0;
      bus.seg_valid  = 1'b0;
      bus.prod_ready = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
      bus.op_signed  = 1'b0;
`endif
      test_reset();
      test_basic();
      test_max();
      test_zero();
      test_hold();
      test_reset_mid();
      test_back_to_back();
`ifdef SEQ_MULT_SIGNED_EN
      test_signed();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seq_mult_seg.md
# seq_mult_seg

Parametrised sequential shift-add multiplier with a segment-serial operand loader and a valid/ready result port. Operands arrive SEG_W bits per transfer over a narrow pin-limited input bus. The product is formed one multiplier bit per cycle and held until the consumer accepts it. It generalises the fixed 4x4 combinational array multiplier and the nibble-serial instruction latch into one configurable coprocessor-side datapath.

## Interface
- WIDTH, 8: operand width in bits; must be a multiple of SEG_W and at least SEG_W.
- SEG_W, 4: bits per input transfer.
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- seg_in  in  SEG_W  operand segment data.
- seg_valid  in  1  seg_in holds a segment.
- seg_ack  out  1  combinational; high when state is LOAD and seg_valid is high; transfer occurs when this is high at a clock edge.
- prod  out  2*WIDTH  product; full width, never truncated.
- prod_valid  out  1  prod holds a completed result.
- prod_ready  in  1  consumer accepts prod.
- busy  out  1  high in RUN and DONE.
- op_signed  in  1  present only with SEQ_MULT_SIGNED_EN; selects two's-complement operands.

## Operation
- NSEG = WIDTH/SEG_W. Each operation needs 2*NSEG transfers: operand A first, then operand B, least-significant segment first.
- States:
  - LOAD: each transfer writes seg_in into segment slot seg_cnt and increments seg_cnt. The transfer with seg_cnt = 2*NSEG-1 clears seg_cnt, clears acc, zeroes bit_cnt and moves the block to RUN.
  - RUN: runs one step per cycle on multiplier bit bit_cnt. If that bit is 1, the block adds A, aligned to bit bit_cnt, into acc. After WIDTH steps the block moves to DONE.
  - DONE: prod_valid is high. When prod_ready is high at an edge, the block returns to LOAD.
- seg_ack is low in RUN and DONE. seg_valid in those states is ignored and no data is lost from the block's view; the sender holds the segment until it is acked.
- prod is driven from acc and changes only in RUN. It is stable for the whole of DONE.
- Arithmetic: acc is 2*WIDTH+1 bits internally so the carry is kept. prod takes the low 2*WIDTH bits, which is exact for unsigned operands.
- Counter widths: seg_cnt uses $clog2(2*NSEG), bit_cnt uses $clog2(WIDTH+1). Neither counter wraps, because the state changes before its terminal value is exceeded.

## Timing
- Reset values: state LOAD, seg_cnt 0, bit_cnt 0, acc 0, prod 0, prod_valid 0, busy 0. seg_ack is forced low while rst is high.
- Reset mid-operation, in any state, discards loaded segments and any partial product. The next transfer after reset is slot 0 (A, least-significant segment).
- Latency: if the final segment is accepted at edge E, busy is high from E. prod_valid rises at edge E+WIDTH.
- prod_ready high in the same cycle prod_valid first rises completes the handshake at the next edge, E+WIDTH+1. That cycle is a one-cycle DONE.
- After the result handshake, seg_ack can be high in the very next cycle. This gives back-to-back throughput of 2*NSEG+WIDTH+1 cycles per product with no idle gap.
- prod_ready while prod_valid is low has no effect.

## Configuration
- SEQ_MULT_SIGNED_EN defined:
  - op_signed port exists and is sampled at the final-segment transfer.
  - When op_signed is 1, A is sign-extended in acc additions and the last RUN step (the B MSB step) subtracts instead of adds. prod is then the exact two's-complement product.
- SEQ_MULT_SIGNED_EN undefined: the port is absent and the block is unsigned only. Latency is identical in both builds.

## Structure
- Package seq_mult_pkg holds:
  - the state enum (LOAD, RUN, DONE), encoded 2'b00, 2'b01, 2'b10; 2'b11 is unreachable and recovers to LOAD;
  - helper localparam functions for NSEG and the counter widths.
- One sub-module, seg_deser, holds the LOAD-side slot counter and the A/B operand registers and exposes a load_done pulse. The RUN/DONE FSM and accumulator sit in the top level.

## Test plan
- WIDTH=8, segments 7,B,C,5 (A=0xB7, B=0x5C): prod = 0x41C4, with prod_valid exactly 8 edges after the final transfer.
- A=0xFF, B=0xFF: prod = 0xFE01, with no carry loss.
- A=0x00, B=0xA5: prod = 0x0000; latency is still 8 cycles and busy stays high throughout.
- prod_ready held low 5 cycles in DONE with seg_valid high:
  - prod_valid and prod stay stable and seg_ack stays 0;
  - after the handshake, seg_ack = 1 on the following cycle.
- rst pulsed after 3 of 4 transfers, then segments 3,0,2,0 sent: prod = 0x0006 and all outputs are 0 during reset.
- SEQ_MULT_SIGNED_EN, A=0xFE, B=0x03: op_signed=1 gives prod = 0xFFFA; op_signed=0 gives 0x02FA.
